xs3_to_binary_serial: RTL and testbench

//   Decode side of the Excess-3 arithmetic path. Converts a packed NDIG-digit Excess-3 number
//   (the format produced by the Excess-3 adder) into a plain unsigned binary value.

---
 rtl/xs3_pkg.sv | 24 ++
 rtl/xs3_digit_decode.sv | 16 +
 rtl/xs3_to_binary_serial.sv | 115 +++++++++++
 tb/tb_xs3_to_binary_serial.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/xs3_pkg.sv
// Shared Excess-3 definitions: state encoding, code limits and a validity helper.
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } xs3_state_e;

    // Legacy-compatible state constants used by the converter FSM
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    // True when the nibble is a legal Excess-3 code (decimal 0..9)
    function automatic logic xs3_is_valid(input logic [3:0] code);
        return (code >= XS3_MIN) && (code <= XS3_MAX);
    endfunction

endpackage

// File: rtl/xs3_digit_decode.sv
// Combinational Excess-3 nibble decoder; illegal codes decode to digit 0 with invalid set.
module xs3_digit_decode
    import xs3_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] digit,
    output logic       invalid
);

    // Strip the excess-3 offset, forcing zero for illegal codes
    always_comb begin
        invalid = !xs3_is_valid(code);
        digit   = invalid ? 4'd0 : (code - XS3_OFFSET);
    end

endmodule

// File: rtl/xs3_to_binary_serial.sv
// Digit-serial Excess-3 to binary converter, MSD first, one digit per clock.
module xs3_to_binary_serial
    import xs3_pkg::*;
#(
    parameter int unsigned NDIG = 4,
    parameter int unsigned BW   = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*NDIG-1:0]   xs3_in,
    output logic                ready,
    output logic                valid,
    output logic [BW-1:0]       bin_out,
    output logic                err
);

    localparam int unsigned XW = 4 * NDIG;
    localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [1:0]    state,   state_nx;
    logic [XW-1:0] sreg,    sreg_nx;
    logic [BW-1:0] acc,     acc_nx;
    logic          err_acc, err_acc_nx;
    logic [CW-1:0] cnt,     cnt_nx;
    logic [BW-1:0] bin_nx;
    logic          err_nx;
    logic          ready_nx;
    logic          valid_nx;

    logic [3:0]    dig;
    logic          dig_invalid;
    logic [BW-1:0] acc_mac;

    // Decode the digit currently at the top of the shift register
    xs3_digit_decode u_decode (
        .code    (sreg[XW-1 -: 4]),
        .digit   (dig),
        .invalid (dig_invalid)
    );

    // acc*10 + digit built from shifts in a widened word, then truncated back to BW
    always_comb begin
        acc_mac = BW'(({4'b0, acc} << 3) + ({4'b0, acc} << 1) + (BW + 4)'(dig));
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        acc_nx     = acc;
        err_acc_nx = err_acc;
        cnt_nx     = cnt;
        bin_nx     = bin_out;
        err_nx     = err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    sreg_nx    = xs3_in;
                    acc_nx     = '0;
                    err_acc_nx = 1'b0;
                    cnt_nx     = CW'(NDIG - 1);
                    state_nx   = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_nx     = acc_mac;
                err_acc_nx = err_acc | dig_invalid;
                sreg_nx    = sreg << 4;
                cnt_nx     = cnt - CW'(1);
                if (cnt == '0) begin
                    bin_nx   = acc_mac;
                    err_nx   = err_acc | dig_invalid;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        ready_nx = (state_nx == ST_IDLE);
        valid_nx = (state_nx == ST_DONE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            acc     <= '0;
            err_acc <= 1'b0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
            ready   <= 1'b1;
            valid   <= 1'b0;
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            acc     <= acc_nx;
            err_acc <= err_acc_nx;
            cnt     <= cnt_nx;
            bin_out <= bin_nx;
            err     <= err_nx;
            ready   <= ready_nx;
            valid   <= valid_nx;
        end
    end

endmodule

// File: tb/tb_xs3_to_binary_serial.sv
// Scoreboard bench for xs3_to_binary_serial: directed cases plus random conversions.
module tb_xs3_to_binary_serial;

    localparam int unsigned NDIG = 4;
    localparam int unsigned BW   = 14;
    localparam int unsigned XW   = 4 * NDIG;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          start  = 1'b0;
    logic [XW-1:0] xs3_in = '0;
    logic          ready;
    logic          valid;
    logic [BW-1:0] bin_out;
    logic          err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int val;
        bit e;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   m_busy   = 0;
    int   acc_cnt  = 0;
    int   hold_val = 0;
    bit   hold_err = 1'b0;

    xs3_to_binary_serial #(.NDIG(NDIG), .BW(BW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .xs3_in  (xs3_in),
        .ready   (ready),
        .valid   (valid),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Reference: each legal code contributes (code-3)*10^position; any illegal code flags err
    function automatic void ref_model(input logic [XW-1:0] x, output int val, output bit e);
        int p = 1;
        int code;
        val = 0;
        e   = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            code = int'(x[4*i +: 4]);
            if (code >= 3 && code <= 12) val = val + (code - 3) * p;
            else e = 1'b1;
            p = p * 10;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timing model: an accepted request is due NDIG edges later and blocks new starts for NDIG+1 edges
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 0;
            exp_q.delete();
            hold_val = 0;
            hold_err = 1'b0;
        end else begin
            cyc++;
            if (m_busy == 0 && start) begin
                exp_t t;
                ref_model(xs3_in, t.val, t.e);
                t.due = cyc + int'(NDIG);
                exp_q.push_back(t);
                m_busy = int'(NDIG) + 1;
                acc_cnt++;
            end else if (m_busy > 0) begin
                m_busy--;
            end
        end
    end

    // Monitor: compare handshake and held results every cycle, pop on expected valid
    always @(negedge clk) begin
        bit exp_v;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("ready", int'(ready), int'(m_busy == 0));
        chk("valid", int'(valid), int'(exp_v));
        if (exp_v) begin
            exp_t t;
            t = exp_q.pop_front();
            hold_val = t.val;
            hold_err = t.e;
        end
        chk("bin_out", int'(bin_out), hold_val);
        chk("err", int'(err), int'(hold_err));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic conv(input logic [XW-1:0] x);
        int n = acc_cnt;
        start  = 1'b1;
        xs3_in = x;
        for (int k = 0; k < 20 && acc_cnt == n; k++) tick();
        chk("accept", int'(acc_cnt != n), 1);
        start  = 1'b0;
        xs3_in = XW'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (exp_q.size() != 0 || m_busy != 0); k++) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    function automatic logic [XW-1:0] rand_xs3();
        logic [XW-1:0] x;
        for (int i = 0; i < int'(NDIG); i++) begin
            if ($urandom_range(0, 9) < 8) x[4*i +: 4] = 4'($urandom_range(3, 12));
            else                          x[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return x;
    endfunction

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic conversions and boundaries
        conv(16'h4567); drain();
        conv(16'hCCCC); drain();
        conv(16'h3333); drain();
        conv(16'h45F7); drain();
        conv(16'h3334); drain();

        // Start pulses during conversion are ignored
        conv(16'h4567);
        start  = 1'b1;
        xs3_in = 16'hCCCC;
        repeat (4) tick();
        start  = 1'b0;
        drain();

        // Reset mid-conversion aborts without a result
        conv(16'h4567);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        conv(16'h3339); drain();

        // Back-to-back with start held high
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            xs3_in = rand_xs3();
            tick();
        end
        start = 1'b0;
        drain();

        // Random conversions with random gaps
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            conv(rand_xs3());
        end
        drain();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
